dsha_nonce_scheduler: RTL

//  Sequences dsha_finisher over a nonce range for one job.

---
 rtl/dsha_nonce_scheduler.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dsha_nonce_scheduler.sv
// rtl/dsha_nonce_scheduler.sv - nonce range sequencer and hit filter in front of dsha_finisher
//
// Purpose:
//   Accepts one job (midstate X, tail Y, inclusive nonce range, difficulty),
//   feeds the iterative finisher one nonce every ISSUE_INTERVAL cycles and
//   follows each nonce through a FIN_LATENCY-deep strobe line. When a strobe
//   leaves the line, the hash on fin_hash belongs to the oldest outstanding
//   nonce. That hash is tested for job_zbits leading zero bits, and hits are
//   held in a one-entry register for the host.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   job_valid/job_ready          job handshake; job_* fields are latched on accept
//   abort                        cancel the running job (no done pulse)
//   fin_X, fin_Y, fin_nonce      operands driven to the finisher
//   fin_hash, fin_out_nonce      finisher result and the nonce it reports
//   found_valid/ready/nonce      one-entry hit holding register toward the host
//   busy, done                   status; done pulses once when a range completes
//   nonces_done, hits_dropped    per-job counters (wrapping / saturating)
//   nonce_mismatch               sticky: finisher reported an unexpected nonce
module dsha_nonce_scheduler #(
    parameter int ISSUE_INTERVAL = 64,
    parameter int FIN_LATENCY    = 130
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_midstate,
    input  logic [95:0]  job_tail,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic [7:0]   job_zbits,
    input  logic         abort,
    output logic [255:0] fin_X,
    output logic [95:0]  fin_Y,
    output logic [31:0]  fin_nonce,
    input  logic [255:0] fin_hash,
    input  logic [31:0]  fin_out_nonce,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic         busy,
    output logic         done,
    output logic [31:0]  nonces_done,
    output logic [15:0]  hits_dropped,
    output logic         nonce_mismatch
);

    // Worst-case number of nonces between issue and check.
    localparam int MAX_INFLIGHT = (FIN_LATENCY + ISSUE_INTERVAL - 1) / ISSUE_INTERVAL;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);
    localparam int TMR_W        = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [255:0]             fin_x_q, fin_x_d;
    logic [95:0]              fin_y_q, fin_y_d;
    logic [31:0]              fin_nonce_q, fin_nonce_d;
    logic [31:0]              cur_q, cur_d;
    logic [31:0]              last_q, last_d;
    logic [7:0]               zbits_q, zbits_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [FIN_LATENCY-1:0]   strobe_q, strobe_d;
    logic [31:0]              expq_q [MAX_INFLIGHT];
    logic [31:0]              expq_d [MAX_INFLIGHT];
    logic [CNT_W-1:0]         qcnt_q, qcnt_d;
    logic                     found_valid_q, found_valid_d;
    logic [31:0]              found_nonce_q, found_nonce_d;
    logic [31:0]              nonces_done_q, nonces_done_d;
    logic [15:0]              hits_dropped_q, hits_dropped_d;
    logic                     mismatch_q, mismatch_d;

    logic                     accept;
    logic                     abort_act;
    logic                     issue;
    logic                     check;
    logic                     hit;
    logic                     pop_found;
    logic [255:0]             hash_mask;
    logic [CNT_W-1:0]         wr_idx;

    assign accept    = (state_q == S_IDLE) && job_valid;
    assign abort_act = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign issue     = (state_q == S_RUN) && (tmr_q == '0) && !abort;
    // A strobe leaving the line means fin_hash now belongs to expq_q[0].
    assign check     = strobe_q[FIN_LATENCY-1] && !abort_act;
    // Top zbits_q bits set; zbits_q == 0 gives an empty mask, so every hash hits.
    assign hash_mask = ~({256{1'b1}} >> zbits_q);
    assign hit       = check && ((fin_hash & hash_mask) == '0);
    assign pop_found = found_valid_q && found_ready;
    // A simultaneous pop frees the head slot before the push lands.
    assign wr_idx    = check ? (qcnt_q - CNT_W'(1)) : qcnt_q;

    always_comb begin
        state_d        = state_q;
        fin_x_d        = fin_x_q;
        fin_y_d        = fin_y_q;
        fin_nonce_d    = fin_nonce_q;
        cur_d          = cur_q;
        last_d         = last_q;
        zbits_d        = zbits_q;
        tmr_d          = tmr_q;
        strobe_d       = {strobe_q[FIN_LATENCY-2:0], issue};
        expq_d         = expq_q;
        qcnt_d         = qcnt_q;
        found_valid_d  = found_valid_q;
        found_nonce_d  = found_nonce_q;
        nonces_done_d  = nonces_done_q;
        hits_dropped_d = hits_dropped_q;
        mismatch_d     = mismatch_q;

        // Expected-nonce queue: pop on check, push on issue.
        if (abort_act) begin
            qcnt_d   = '0;
            strobe_d = '0;
        end else begin
            if (check) begin
                for (int i = 0; i < MAX_INFLIGHT - 1; i++) begin
                    expq_d[i] = expq_q[i+1];
                end
            end
            if (issue) begin
                for (int i = 0; i < MAX_INFLIGHT; i++) begin
                    if (i == int'(wr_idx)) begin
                        expq_d[i] = cur_q;
                    end
                end
            end
            qcnt_d = qcnt_q + CNT_W'(issue) - CNT_W'(check);
        end

        // The reported nonce is always the one we issued, even if the
        // finisher echoes something else back.
        if (check) begin
            nonces_done_d = nonces_done_q + 32'd1;
            if (fin_out_nonce != expq_q[0]) begin
                mismatch_d = 1'b1;
            end
        end

        if (hit) begin
            if (!found_valid_q || pop_found) begin
                found_valid_d = 1'b1;
                found_nonce_d = expq_q[0];
            end else if (hits_dropped_q != 16'hFFFF) begin
                hits_dropped_d = hits_dropped_q + 16'd1;
            end
        end else if (pop_found) begin
            found_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d        = S_RUN;
                    fin_x_d        = job_midstate;
                    fin_y_d        = job_tail;
                    cur_d          = job_nonce_start;
                    last_d         = job_nonce_end;
                    zbits_d        = job_zbits;
                    tmr_d          = '0;
                    nonces_done_d  = '0;
                    mismatch_d     = 1'b0;
                    hits_dropped_d = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = (tmr_q == TMR_W'(ISSUE_INTERVAL - 1)) ? '0 : tmr_q + TMR_W'(1);
                    if (issue) begin
                        fin_nonce_d = cur_q;
                        // Equality (not <=) so wrapped ranges and the full
                        // 2^32 range (start == end + 1) terminate correctly.
                        if (cur_q == last_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            cur_d = cur_q + 32'd1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (strobe_q[FIN_LATENCY-2:0] == '0) begin
                    // Last strobe is being checked this cycle.
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            fin_x_q        <= '0;
            fin_y_q        <= '0;
            fin_nonce_q    <= '0;
            cur_q          <= '0;
            last_q         <= '0;
            zbits_q        <= '0;
            tmr_q          <= '0;
            strobe_q       <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                expq_q[i] <= '0;
            end
            qcnt_q         <= '0;
            found_valid_q  <= 1'b0;
            found_nonce_q  <= '0;
            nonces_done_q  <= '0;
            hits_dropped_q <= '0;
            mismatch_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            fin_x_q        <= fin_x_d;
            fin_y_q        <= fin_y_d;
            fin_nonce_q    <= fin_nonce_d;
            cur_q          <= cur_d;
            last_q         <= last_d;
            zbits_q        <= zbits_d;
            tmr_q          <= tmr_d;
            strobe_q       <= strobe_d;
            expq_q         <= expq_d;
            qcnt_q         <= qcnt_d;
            found_valid_q  <= found_valid_d;
            found_nonce_q  <= found_nonce_d;
            nonces_done_q  <= nonces_done_d;
            hits_dropped_q <= hits_dropped_d;
            mismatch_q     <= mismatch_d;
        end
    end

    assign job_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign fin_X          = fin_x_q;
    assign fin_Y          = fin_y_q;
    assign fin_nonce      = fin_nonce_q;
    assign found_valid    = found_valid_q;
    assign found_nonce    = found_nonce_q;
    assign nonces_done    = nonces_done_q;
    assign hits_dropped   = hits_dropped_q;
    assign nonce_mismatch = mismatch_q;

endmodule
